// File: rtl/fifo_psum_accum.sv
// Drains show-ahead FIFO words into per-lane signed partial sums and emits one
// (optionally ReLU-clamped) result vector per group of cfg_len+1 popped words.
module fifo_psum_accum #(
  parameter int bw      = 8,
  parameter int simd    = 4,
  parameter int psum_bw = 12
) (
  input  logic                    rd_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              cfg_len,
  input  logic [3:0]              cfg_num,
  input  logic                    relu_en,
  input  logic                    fifo_empty,
  input  logic [simd*bw-1:0]      fifo_out,
  output logic                    fifo_rd,
  output logic [simd*psum_bw-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         num_q, num_d;
  logic               relu_q, relu_d;
  logic [3:0]         vec_cnt_q, vec_cnt_d;
  logic [3:0]         out_cnt_q, out_cnt_d;
  logic [psum_bw-1:0] acc_q [simd];
  logic [psum_bw-1:0] acc_d [simd];

  always_comb begin
    fifo_rd   = (state_q == ACC) && !fifo_empty;
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    num_d     = num_q;
    relu_d    = relu_q;
    vec_cnt_d = vec_cnt_q;
    out_cnt_d = out_cnt_q;
    for (int unsigned i = 0; i < simd; i++) acc_d[i] = acc_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          num_d     = cfg_num;
          relu_d    = relu_en;
          vec_cnt_d = '0;
          out_cnt_d = '0;
          for (int unsigned i = 0; i < simd; i++) acc_d[i] = '0;
          state_d   = ACC;
        end
      end
      ACC: begin
        if (fifo_rd) begin
          // Sign-extend each lane to psum_bw; headroom makes overflow impossible.
          for (int unsigned i = 0; i < simd; i++)
            acc_d[i] = acc_q[i] +
                       {{(psum_bw-bw){fifo_out[i*bw+bw-1]}}, fifo_out[i*bw +: bw]};
          vec_cnt_d = vec_cnt_q + 4'd1;
          if (vec_cnt_q == len_q) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          for (int unsigned i = 0; i < simd; i++) acc_d[i] = '0;
          vec_cnt_d = '0;
          out_cnt_d = out_cnt_q + 4'd1;
          state_d   = (out_cnt_q == num_q) ? DONE : ACC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < simd; i++) begin
      if (out_valid && !(relu_q && acc_q[i][psum_bw-1]))
        out_data[i*psum_bw +: psum_bw] = acc_q[i];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      num_q     <= '0;
      relu_q    <= 1'b0;
      vec_cnt_q <= '0;
      out_cnt_q <= '0;
      for (int unsigned i = 0; i < simd; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      num_q     <= num_d;
      relu_q    <= relu_d;
      vec_cnt_q <= vec_cnt_d;
      out_cnt_q <= out_cnt_d;
      for (int unsigned i = 0; i < simd; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule
